// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath width and serial FSM encodings.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A - B - BI, BO = borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic BI,
    output logic D,
    output logic BO
);

    always_comb begin
        D  = A ^ B ^ BI;
        BO = (~A & B) | (~(A ^ B) & BI);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock; flags latched on completion.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic fs_d, fs_bo;

    full_subtractor u_fs (
        .A  (a_sh_q[0]),
        .B  (b_sh_q[0]),
        .BI (brw_q),
        .D  (fs_d),
        .BO (fs_bo)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                d_sh_d = {fs_d, d_sh_q[WIDTH-1:1]};
                brw_d  = fs_bo;
                if (cnt_q == LAST) begin
                    // results publish only here so they stay frozen while busy
                    state_d  = ST_DONE;
                    diff_d   = d_sh_d;
                    borrow_d = fs_bo;
                    zero_d   = (d_sh_d == '0);
                    ovf_d    = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of the 8-bit serial subtractor with immediate assertions.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] diff;
    logic       borrow, zero, ovf;

    int vecs = 0;
    int errs = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input string tag, input logic [7:0] av,
                          input logic [7:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_on"}, busy, 1'b1);
        chk({tag, "_done_off"}, done, 1'b0);
    endtask

    // Waits out edges 1..8 after acceptance; done must rise only after edge 8.
    task automatic finish_op(input string tag, input bit poke,
                             input logic [7:0] ed, input logic eb,
                             input logic ez, input logic eo);
        bit early = 1'b0;
        for (int i = 1; i < 8; i++) begin
            if (i == 2) begin
                a = ~a;
                b = b ^ 8'h5a;
            end
            if (poke && i == 3) begin
                start = 1'b1;
                a = 8'hff;
                b = 8'hff;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done || !busy) early = 1'b1;
        end
        chk({tag, "_no_early_done"}, early, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_off"}, busy, 1'b0);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow, eb);
        chk({tag, "_zero"}, zero, ez);
        chk({tag, "_ovf"}, ovf, eo);
    endtask

    task automatic after_idle(input string tag, input logic [7:0] ed);
        @(posedge clk); #1;
        chk({tag, "_done_pulse1"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_diff_hold"}, diff, ed);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_flags", {borrow, zero, ovf}, 3'b000);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        launch("basic", 8'h05, 8'h03);
        finish_op("basic", 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        after_idle("basic", 8'h02);

        launch("brw", 8'h03, 8'h05);
        finish_op("brw", 1'b0, 8'hfe, 1'b1, 1'b0, 1'b0);
        after_idle("brw", 8'hfe);

        launch("ovf", 8'h80, 8'h01);
        finish_op("ovf", 1'b0, 8'h7f, 1'b0, 1'b0, 1'b1);
        after_idle("ovf", 8'h7f);

        launch("zero", 8'h2a, 8'h2a);
        finish_op("zero", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        after_idle("zero", 8'h00);

        launch("busy_start", 8'h10, 8'h01);
        finish_op("busy_start", 1'b1, 8'h0f, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("busy_start_single_done", seen, 1'b0);
        chk("busy_start_diff_hold", diff, 8'h0f);

        launch("rst_mid", 8'hc3, 8'h5a);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_diff", diff, 8'h00);
        chk("rst_mid_flags", {borrow, zero, ovf}, 3'b000);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("rst_mid_no_done", seen, 1'b0);

        launch("post_rst", 8'h7f, 8'h80);
        finish_op("post_rst", 1'b0, 8'hff, 1'b1, 1'b0, 1'b1);
        after_idle("post_rst", 8'hff);

        launch("b2b_first", 8'h40, 8'h10);
        finish_op("b2b_first", 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        launch("b2b_second", 8'h00, 8'h01);
        finish_op("b2b_second", 1'b0, 8'hff, 1'b1, 1'b0, 1'b0);
        after_idle("b2b_second", 8'hff);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
